// File: rtl/cordic_alu_sequencer_if.sv
// cordic_alu_sequencer_if
//   Request/response and shared-ALU/ROM bus of the CORDIC sequencer.
//   slave  : the sequencer (takes START/X/Y/Z_IN, ALU_RESULT, ATAN_DATA;
//            drives BUSY, DONE, X/Y/Z_OUT, ALU operands, ATAN_ADDR)
//   master : the surrounding system (requester + ALU + arctan ROM)
interface cordic_alu_sequencer_if #(
    parameter int FIXED_POINT = 16,
    parameter int ITERATIONS  = 16
);
    localparam int AW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    logic                   START;
    logic [FIXED_POINT-1:0] X_IN, Y_IN, Z_IN;
    logic                   BUSY;
    logic                   DONE;
    logic [FIXED_POINT-1:0] X_OUT, Y_OUT, Z_OUT;
    logic [FIXED_POINT-1:0] ALU_OPERAND_A, ALU_OPERAND_B;
    logic                   ALU_ADD_SUB;
    logic [FIXED_POINT-1:0] ALU_RESULT;
    logic [AW-1:0]          ATAN_ADDR;
    logic [FIXED_POINT-1:0] ATAN_DATA;

    modport slave (
        input  START, X_IN, Y_IN, Z_IN, ALU_RESULT, ATAN_DATA,
        output BUSY, DONE, X_OUT, Y_OUT, Z_OUT,
               ALU_OPERAND_A, ALU_OPERAND_B, ALU_ADD_SUB, ATAN_ADDR
    );

    modport master (
        output START, X_IN, Y_IN, Z_IN, ALU_RESULT, ATAN_DATA,
        input  BUSY, DONE, X_OUT, Y_OUT, Z_OUT,
               ALU_OPERAND_A, ALU_OPERAND_B, ALU_ADD_SUB, ATAN_ADDR
    );
endinterface

// File: rtl/cordic_alu_sequencer.sv
// cordic_alu_sequencer
//   Iterative rotation-mode CORDIC controller time-sharing one add/sub ALU.
//   Each micro-rotation takes three cycles: CALC_X, CALC_Y, CALC_Z.
//   Ports:
//     CLK  - clock, rising edge
//     RST  - synchronous active-low reset
//     bus  - cordic_alu_sequencer_if.slave (request, result, ALU, ROM)
module cordic_alu_sequencer #(
    parameter int FIXED_POINT = 16,
    parameter int ITERATIONS  = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    cordic_alu_sequencer_if.slave  bus
);
    localparam int AW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    typedef enum logic [2:0] {IDLE, CALC_X, CALC_Y, CALC_Z, FINISH} state_t;

    state_t                 state;
    logic [AW-1:0]          iter;
    logic [FIXED_POINT-1:0] x, y, z, x_tmp;
    logic                   busy, done;

    // Rotation direction comes from Z, which only changes at the CALC_Z edge,
    // so it is stable across all three phases of an iteration.
    logic d;
    assign d = z[FIXED_POINT-1];

    logic [FIXED_POINT-1:0] x_sh, y_sh;
    assign x_sh = $signed(x) >>> iter;
    assign y_sh = $signed(y) >>> iter;

    // Shared ALU bus is a pure decode of the current phase.
    always_comb begin
        bus.ALU_OPERAND_A = '0;
        bus.ALU_OPERAND_B = '0;
        bus.ALU_ADD_SUB   = 1'b0;
        case (state)
            CALC_X: begin
                bus.ALU_OPERAND_A = x;
                bus.ALU_OPERAND_B = y_sh;
                bus.ALU_ADD_SUB   = ~d;
            end
            CALC_Y: begin
                // x still holds the pre-iteration value; new X sits in x_tmp
                bus.ALU_OPERAND_A = y;
                bus.ALU_OPERAND_B = x_sh;
                bus.ALU_ADD_SUB   = d;
            end
            CALC_Z: begin
                bus.ALU_OPERAND_A = z;
                bus.ALU_OPERAND_B = bus.ATAN_DATA;
                bus.ALU_ADD_SUB   = ~d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            iter  <= '0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            x_tmp <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        x     <= bus.X_IN;
                        y     <= bus.Y_IN;
                        z     <= bus.Z_IN;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= CALC_X;
                    end
                end
                CALC_X: begin
                    x_tmp <= bus.ALU_RESULT;
                    state <= CALC_Y;
                end
                CALC_Y: begin
                    y     <= bus.ALU_RESULT;
                    state <= CALC_Z;
                end
                CALC_Z: begin
                    z <= bus.ALU_RESULT;
                    x <= x_tmp;
                    if (iter == AW'(ITERATIONS - 1)) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        iter  <= iter + 1'b1;
                        state <= CALC_X;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.X_OUT     = x;
    assign bus.Y_OUT     = y;
    assign bus.Z_OUT     = z;
    assign bus.BUSY      = busy;
    assign bus.DONE      = done;
    assign bus.ATAN_ADDR = iter;

endmodule

// File: tb/tb_cordic_alu_sequencer.sv
// tb_cordic_alu_sequencer
//   Directed bench: bench-side modular ALU and arctan ROM (Z scaled 2^11),
//   independent CORDIC reference, phase/timing/reset/wrap scenarios.
module tb_cordic_alu_sequencer;
    localparam int FP = 16;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cordic_alu_sequencer_if #(.FIXED_POINT(FP), .ITERATIONS(N)) bus ();

    cordic_alu_sequencer #(.FIXED_POINT(FP), .ITERATIONS(N)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_tot = 0;
    int n_bad = 0;

    // atan(2^-i) * 2048, rounded
    function automatic logic [FP-1:0] rom_val(input int i);
        case (i)
            0: rom_val = 16'h0648;
            1: rom_val = 16'h03B6;
            2: rom_val = 16'h01F6;
            3: rom_val = 16'h00FF;
            4: rom_val = 16'h0080;
            5: rom_val = 16'h0040;
            6: rom_val = 16'h0020;
            7: rom_val = 16'h0010;
            8: rom_val = 16'h0008;
            9: rom_val = 16'h0004;
            10: rom_val = 16'h0002;
            11: rom_val = 16'h0001;
            default: rom_val = 16'h0000;
        endcase
    endfunction

    assign bus.ATAN_DATA  = rom_val(int'(bus.ATAN_ADDR));
    assign bus.ALU_RESULT = bus.ALU_ADD_SUB ? bus.ALU_OPERAND_A - bus.ALU_OPERAND_B
                                            : bus.ALU_OPERAND_A + bus.ALU_OPERAND_B;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Textbook rotation-mode CORDIC, wrapping modulo 2^16.
    task automatic model(input logic [FP-1:0] xi, yi, zi,
                         output logic [FP-1:0] xo, yo, zo);
        logic signed [FP-1:0] x, y, z, xn, yn;
        x = xi; y = yi; z = zi;
        for (int i = 0; i < N; i++) begin
            if (z[FP-1]) begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
                z  = z + rom_val(i);
            end else begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
                z  = z - rom_val(i);
            end
            x = xn; y = yn;
        end
        xo = x; yo = y; zo = z;
    endtask

    task automatic chk_result(input string tag, input logic [FP-1:0] xi, yi, zi);
        logic [FP-1:0] ex, ey, ez;
        model(xi, yi, zi, ex, ey, ez);
        chk({tag, "_x"}, 32'(bus.X_OUT), 32'(ex));
        chk({tag, "_y"}, 32'(bus.Y_OUT), 32'(ey));
        chk({tag, "_z"}, 32'(bus.Z_OUT), 32'(ez));
    endtask

    logic [FP-1:0] cap_a [0:7];
    logic [FP-1:0] cap_b [0:7];
    logic          cap_s [0:7];
    logic [FP-1:0] cap_x4, cap_y4, cap_z4;

    // One full operation: START sampled at edge T0, observe cycles T0+1..T0+50.
    task automatic run_op(input string tag, input logic [FP-1:0] xi, yi, zi);
        int cyc, busy_n, done_n, done_cyc;
        @(negedge clk);
        bus.START = 1'b1; bus.X_IN = xi; bus.Y_IN = yi; bus.Z_IN = zi;
        @(posedge clk); #1;
        bus.START = 1'b0;
        busy_n = 0; done_n = 0; done_cyc = 0;
        for (cyc = 1; cyc <= 50; cyc++) begin
            if (cyc < 8) begin
                cap_a[cyc] = bus.ALU_OPERAND_A;
                cap_b[cyc] = bus.ALU_OPERAND_B;
                cap_s[cyc] = bus.ALU_ADD_SUB;
            end
            if (cyc == 4) begin
                cap_x4 = bus.X_OUT; cap_y4 = bus.Y_OUT; cap_z4 = bus.Z_OUT;
            end
            if (cyc <= 48 && (cyc - 1) % 3 == 0)
                chk({tag, "_atan_addr"}, 32'(bus.ATAN_ADDR), 32'((cyc - 1) / 3));
            busy_n += int'(bus.BUSY);
            if (bus.DONE) begin done_n++; done_cyc = cyc; end
            if (cyc < 50) begin @(posedge clk); #1; end
        end
        chk({tag, "_done_cyc"}, 32'(done_cyc), 32'd49);
        chk({tag, "_done_cnt"}, 32'(done_n), 32'd1);
        chk({tag, "_busy_cnt"}, 32'(busy_n), 32'd49);
        chk_result(tag, xi, yi, zi);
    endtask

    initial begin
        logic [FP-1:0] rx, ry, rz;
        int done_n;
        bus.START = 1'b0; bus.X_IN = '0; bus.Y_IN = '0; bus.Z_IN = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.BUSY), 0);
        chk("rst_done", 32'(bus.DONE), 0);
        chk("rst_x", 32'(bus.X_OUT), 0);
        chk("rst_z", 32'(bus.Z_OUT), 0);
        chk("rst_alu_a", 32'(bus.ALU_OPERAND_A), 0);
        chk("rst_atan", 32'(bus.ATAN_ADDR), 0);
        rst = 1'b1;

        // Phase bus check and first iteration state
        run_op("s1", 16'h1000, 16'h0000, 16'h0400);
        chk("s1_a1", 32'(cap_a[1]), 32'h1000);
        chk("s1_b1", 32'(cap_b[1]), 32'h0000);
        chk("s1_s1", 32'(cap_s[1]), 1);
        chk("s1_a2", 32'(cap_a[2]), 32'h0000);
        chk("s1_b2", 32'(cap_b[2]), 32'h1000);
        chk("s1_s2", 32'(cap_s[2]), 0);
        chk("s1_a3", 32'(cap_a[3]), 32'h0400);
        chk("s1_b3", 32'(cap_b[3]), 32'h0648);
        chk("s1_s3", 32'(cap_s[3]), 1);
        chk("s1_x", 32'(cap_x4), 32'h1000);
        chk("s1_y", 32'(cap_y4), 32'h1000);
        chk("s1_z", 32'(cap_z4), 32'hFDB8);
        // iteration 1 rotates negative, shift by 1
        chk("s2_a4", 32'(cap_a[4]), 32'h1000);
        chk("s2_b4", 32'(cap_b[4]), 32'h0800);
        chk("s2_s4", 32'(cap_s[4]), 0);
        chk("idle_alu_b", 32'(bus.ALU_OPERAND_B), 0);

        // Arithmetic shift of a negative Y
        run_op("s2n", 16'h0000, 16'h8000, 16'h0400);
        chk("s2n_b4", 32'(cap_b[4]), 32'hC000);

        // Random vectors against the reference
        for (int k = 0; k < 200; k++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rz = 16'($urandom_range(0, 6430)) - 16'd3215;
            run_op("rnd", rx, ry, rz);
        end

        // START while busy, at FINISH, then earliest restart
        @(negedge clk);
        bus.START = 1'b1; bus.X_IN = 16'h0800; bus.Y_IN = 16'h0100; bus.Z_IN = 16'h0300;
        @(posedge clk); #1;
        done_n = 0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            if (cyc == 10 || cyc >= 49) begin
                bus.START = 1'b1; bus.X_IN = 16'h2000; bus.Y_IN = 16'hF000; bus.Z_IN = 16'hFA00;
            end else begin
                bus.START = 1'b0;
            end
            done_n += int'(bus.DONE);
            if (cyc == 50) begin
                chk("s4_busy50", 32'(bus.BUSY), 0);
                chk_result("s4_first", 16'h0800, 16'h0100, 16'h0300);
            end
            @(posedge clk); #1;
        end
        chk("s4_done_cnt", 32'(done_n), 1);
        chk("s4_busy51", 32'(bus.BUSY), 1);
        bus.START = 1'b0;
        for (int cyc = 0; cyc < 60 && !bus.DONE; cyc++) begin
            @(posedge clk); #1;
        end
        chk("s4_done2", 32'(bus.DONE), 1);
        chk_result("s4_second", 16'h2000, 16'hF000, 16'hFA00);
        @(posedge clk); #1;

        // Reset mid-operation
        @(negedge clk);
        bus.START = 1'b1; bus.X_IN = 16'h1234; bus.Y_IN = 16'h0567; bus.Z_IN = 16'h0200;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("s5_busy", 32'(bus.BUSY), 0);
        chk("s5_done", 32'(bus.DONE), 0);
        chk("s5_xyz", {bus.X_OUT, bus.Y_OUT | bus.Z_OUT}, 0);
        chk("s5_alu", {bus.ALU_OPERAND_A, bus.ALU_OPERAND_B}, 0);
        chk("s5_sub", 32'(bus.ALU_ADD_SUB), 0);
        chk("s5_atan", 32'(bus.ATAN_ADDR), 0);
        @(posedge clk); #1;
        chk("s5_nodone", 32'(bus.DONE), 0);
        run_op("s5_fresh", 16'h1234, 16'h0567, 16'h0200);

        // Wrap-around
        run_op("s6", 16'h7FFF, 16'h7FFF, 16'h7FFF);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
